if_fetch_unit: RTL and testbench

//  IF-stage PC generator and IF/ID pipeline register for the 32-bit 5-stage RV32I pipeline.

---
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// IF-stage PC generator and IF/ID pipeline register for the RV32I 5-stage pipeline.
// Optional performance counters (redir_cnt, stall_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        Branch,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] redir_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic [31:0] buf_q;
    logic        redir;
    logic [31:0] redir_tgt;

    // A stalled ID has unresolved operands, so a concurrent Branch is not trusted.
    assign redir     = Branch & ~stall;
    assign redir_tgt = br_target & ~32'h3;

    // The address comes straight from pc_q, which only moves on an accepted beat or
    // from IDLE/HOLD, so it stays stable for the whole life of a request.
    assign imem_req  = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            tgt_q      <= '0;
            // NOTE: buf_q is a single register, not a memory, so clearing it on reset is cheap.
            buf_q      <= '0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            // NOTE: every state register uses <= so all updates see pre-edge values.
            case (state_q)
                IDLE: state_q <= FETCH;

                FETCH: begin
                    if (imem_ready) begin
                        if (redir) begin
                            pc_q       <= redir_tgt;
                            ifid_instr <= NOP_INSTR;
                            ifid_valid <= 1'b0;
                        end else if (stall) begin
                            buf_q   <= imem_rdata;
                            state_q <= HOLD;
                        end else begin
                            ifid_pc    <= pc_q;
                            ifid_instr <= imem_rdata;
                            ifid_valid <= 1'b1;
                            pc_q       <= pc_q + 32'd4;
                        end
                    end else if (redir) begin
                        tgt_q      <= redir_tgt;
                        state_q    <= DROP;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                end

                DROP: begin
                    if (!stall) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                    // The wrong-path beat is discarded; the newest redirect wins.
                    if (imem_ready) begin
                        pc_q    <= redir ? redir_tgt : tgt_q;
                        state_q <= FETCH;
                    end else if (redir) begin
                        tgt_q <= redir_tgt;
                    end
                end

                HOLD: begin
                    if (!stall) begin
                        if (redir) begin
                            pc_q       <= redir_tgt;
                            ifid_instr <= NOP_INSTR;
                            ifid_valid <= 1'b0;
                        end else begin
                            ifid_pc    <= pc_q;
                            ifid_instr <= buf_q;
                            ifid_valid <= 1'b1;
                            pc_q       <= pc_q + 32'd4;
                        end
                        state_q <= FETCH;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (redir && state_q != IDLE) redir_cnt <= redir_cnt + 32'd1;
            if (stall && state_q != IDLE) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; observed vector is {imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr}.
// Instruction memory returns 0xA000_0000 | addr for every word.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        Branch;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] garble;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redir_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [97:0] obs;
    logic [97:0] exp_v;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    assign imem_rdata = mem(imem_addr) ^ garble;
    assign obs = {imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr};

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .Branch     (Branch),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redir_cnt  (redir_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; Branch = 1'b0; br_target = '0; imem_ready = 1'b1; garble = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL reset_state got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL first_fetch got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'h4, 1'b1, 32'h0, mem(32'h0)}; checks++;
        if (obs !== exp_v) begin $display("FAIL first_valid got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'h8, 1'b1, 32'h4, mem(32'h4)}; checks++;
        if (obs !== exp_v) begin $display("FAIL seq_fetch_8 got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'hC, 1'b1, 32'h8, mem(32'h8)}; checks++;
        if (obs !== exp_v) begin $display("FAIL seq_fetch_c got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        Branch = 1'b1; br_target = 32'h100;
        step();
        exp_v = {1'b1, 32'h100, 1'b0, 32'h4, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL redir_bubble got=%h exp=%h", obs, exp_v); failures++; end
        Branch = 1'b0;
        step();
        exp_v = {1'b1, 32'h104, 1'b1, 32'h100, mem(32'h100)}; checks++;
        if (obs !== exp_v) begin $display("FAIL redir_target got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_wait_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        imem_ready = 1'b0; Branch = 1'b1; br_target = 32'h200;
        step();
        Branch = 1'b0;
        exp_v = {1'b1, 32'hC, 1'b0, 32'h8, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL wait_enter_drop got=%h exp=%h", obs, exp_v); failures++; end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== exp_v) begin $display("FAIL wait_hold_addr cyc=%0d got=%h exp=%h", i, obs, exp_v); failures++; end
        end
        imem_ready = 1'b1;
        step();
        exp_v = {1'b1, 32'h200, 1'b0, 32'h8, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL wait_drop_done got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'h204, 1'b1, 32'h200, mem(32'h200)}; checks++;
        if (obs !== exp_v) begin $display("FAIL wait_target got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        stall = 1'b1;
        step();
        garble = 32'hFFFF_FFFF;   // memory bus is meaningless while parked
        exp_v = {1'b0, 32'h10, 1'b1, 32'hC, mem(32'hC)}; checks++;
        if (obs !== exp_v) begin $display("FAIL stall_park got=%h exp=%h", obs, exp_v); failures++; end
        step();
        checks++;
        if (obs !== exp_v) begin $display("FAIL stall_frozen got=%h exp=%h", obs, exp_v); failures++; end
        stall = 1'b0;
        step();
        garble = '0;
        exp_v = {1'b1, 32'h14, 1'b1, 32'h10, mem(32'h10)}; checks++;
        if (obs !== exp_v) begin $display("FAIL stall_release got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_stall_branch();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        stall = 1'b1; Branch = 1'b1; br_target = 32'h300;
        step();
        exp_v = {1'b0, 32'h8, 1'b1, 32'h4, mem(32'h4)}; checks++;
        if (obs !== exp_v) begin $display("FAIL stall_wins got=%h exp=%h", obs, exp_v); failures++; end
        stall = 1'b0; Branch = 1'b0;
        step();
        exp_v = {1'b1, 32'hC, 1'b1, 32'h8, mem(32'h8)}; checks++;
        if (obs !== exp_v) begin $display("FAIL stall_no_flush got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_drop_newest();
        do_reset();
        step();
        imem_ready = 1'b0; Branch = 1'b1; br_target = 32'h500;
        step();
        br_target = 32'h600;
        step();
        imem_ready = 1'b1; br_target = 32'h700;
        step();
        exp_v = {1'b1, 32'h700, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL drop_same_cycle got=%h exp=%h", obs, exp_v); failures++; end
        Branch = 1'b0;
        step();
        exp_v = {1'b1, 32'h704, 1'b1, 32'h700, mem(32'h700)}; checks++;
        if (obs !== exp_v) begin $display("FAIL drop_resume got=%h exp=%h", obs, exp_v); failures++; end
        imem_ready = 1'b0; Branch = 1'b1; br_target = 32'h900;
        step();
        exp_v = {1'b1, 32'h704, 1'b0, 32'h700, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL drop_enter got=%h exp=%h", obs, exp_v); failures++; end
        br_target = 32'hA00;
        step();
        Branch = 1'b0;
        step();
        imem_ready = 1'b1;
        step();
        exp_v = {1'b1, 32'hA00, 1'b0, 32'h700, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL drop_newest got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'hA04, 1'b1, 32'hA00, mem(32'hA00)}; checks++;
        if (obs !== exp_v) begin $display("FAIL drop_newest_fetch got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_hold_redirect();
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        stall = 1'b0; Branch = 1'b1; br_target = 32'h803;
        step();
        exp_v = {1'b1, 32'h800, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL hold_redir got=%h exp=%h", obs, exp_v); failures++; end
        Branch = 1'b0;
        step();
        exp_v = {1'b1, 32'h804, 1'b1, 32'h800, mem(32'h800)}; checks++;
        if (obs !== exp_v) begin $display("FAIL hold_redir_fetch got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        Branch = 1'b1; br_target = 32'hFFFF_FFFF;
        step();
        exp_v = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL wrap_target got=%h exp=%h", obs, exp_v); failures++; end
        Branch = 1'b0;
        step();
        exp_v = {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC)}; checks++;
        if (obs !== exp_v) begin $display("FAIL wrap_pc got=%h exp=%h", obs, exp_v); failures++; end
    endtask

    task automatic test_rst_mid_wait();
        do_reset();
        for (int i = 0; i < 17; i++) step();
        imem_ready = 1'b0; stall = 1'b1;
        step();
        exp_v = {1'b1, 32'h40, 1'b1, 32'h3C, mem(32'h3C)}; checks++;
        if (obs !== exp_v) begin $display("FAIL wait_at_40 got=%h exp=%h", obs, exp_v); failures++; end
        rst = 1'b1;
        #1;
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL rst_async got=%h exp=%h", obs, exp_v); failures++; end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (redir_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            $display("FAIL rst_counters got=%h/%h exp=0/0", redir_cnt, stall_cnt); failures++;
        end
`endif
        rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        step();
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, NOP}; checks++;
        if (obs !== exp_v) begin $display("FAIL rst_restart got=%h exp=%h", obs, exp_v); failures++; end
        step();
        exp_v = {1'b1, 32'h4, 1'b1, 32'h0, mem(32'h0)}; checks++;
        if (obs !== exp_v) begin $display("FAIL rst_restart_valid got=%h exp=%h", obs, exp_v); failures++; end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        step();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0; Branch = 1'b1; br_target = 32'h40;
        step();
        Branch = 1'b0;
        checks++;
        if (stall_cnt !== 32'd2 || redir_cnt !== 32'd1) begin
            $display("FAIL perf_counts got=%0d/%0d exp=2/1", stall_cnt, redir_cnt); failures++;
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; Branch = 1'b0; br_target = '0; imem_ready = 1'b1; garble = '0;
        test_reset();
        test_redirect();
        test_wait_redirect();
        test_stall();
        test_stall_branch();
        test_drop_newest();
        test_hold_redirect();
        test_wrap();
        test_rst_mid_wait();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
